// File: rtl/csa_pkg.sv
// Shared types and default widths for the carry-save accumulator.
package csa_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int ACC_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUTPUT  = 2'd2
  } csa_state_t;

endpackage

// File: rtl/csa_fa.sv
// One-bit full-adder cell.
module csa_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/csa_row.sv
// 3:2 carry-save compressor row: one full-adder cell per bit, no carry ripple.
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] maj
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    csa_fa u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(c[i]),
      .s (s[i]),
      .co(maj[i])
    );
  end

endmodule

// File: rtl/csa_accumulator.sv
// Frame accumulator: carry-save compress per beat, bit-serial resolve, held result.
// Define CSA_ACC_SAT_EN to saturate out_sum to all ones on overflow (default wraps).
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_ACCUM   | accept operand beats, compress into S/C, in_ready=1
// ST_RESOLVE | add S+C one bit per cycle, LSB first, ACC_W cycles
// ST_OUTPUT  | hold out_sum/out_ovf with out_valid=1 until out_ready
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = (ACC_W > 2) ? $clog2(ACC_W) : 1;

  csa_state_t       state;
  logic [ACC_W-1:0] s_reg;
  logic [ACC_W-1:0] c_reg;
  logic [ACC_W-1:0] d_ext;
  logic [ACC_W-1:0] row_s;
  logic [ACC_W-1:0] row_maj;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             ovf;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             final_ovf;
  logic [ACC_W-1:0] next_sum;
  logic [ACC_W-1:0] result;

  assign d_ext  = {{(ACC_W-WIDTH){1'b0}}, in_data};
  assign accept = in_valid & in_ready;

  csa_row #(.W(ACC_W)) u_row (
    .a  (s_reg),
    .b  (c_reg),
    .c  (d_ext),
    .s  (row_s),
    .maj(row_maj)
  );

  // S and C shift right during resolve, so bit 0 is always the current bit.
  csa_fa u_fa (
    .a (s_reg[0]),
    .b (c_reg[0]),
    .ci(carry),
    .s (fa_s),
    .co(fa_co)
  );

  assign next_sum  = {fa_s, out_sum[ACC_W-1:1]};
  assign final_ovf = ovf | fa_co;

  always_comb begin
    result = next_sum;
`ifdef CSA_ACC_SAT_EN
    if (final_ovf) result = '1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      s_reg     <= '0;
      c_reg     <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            s_reg <= row_s;
            c_reg <= {row_maj[ACC_W-2:0], 1'b0};
            if (row_maj[ACC_W-1]) ovf <= 1'b1;
            if (in_last) begin
              state    <= ST_RESOLVE;
              in_ready <= 1'b0;
              cnt      <= CNT_W'(ACC_W-1);
              carry    <= 1'b0;
            end
          end
        end
        ST_RESOLVE: begin
          s_reg <= s_reg >> 1;
          c_reg <= c_reg >> 1;
          carry <= fa_co;
          if (cnt == '0) begin
            out_sum   <= result;
            out_ovf   <= final_ovf;
            ovf       <= final_ovf;
            out_valid <= 1'b1;
            state     <= ST_OUTPUT;
          end else begin
            out_sum <= next_sum;
            cnt     <= cnt - 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            s_reg     <= '0;
            c_reg     <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_ACCUM;
          end
        end
        default: begin
          state    <= ST_ACCUM;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits.
REQ-002 SHALL have parameter ACC_W, default 8: accumulator/result width, ACC_W > WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operand beat valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts operand beat.
REQ-007 SHALL have port in_data, input, WIDTH: unsigned operand.
REQ-008 SHALL have port in_last, input, 1: beat is final operand of frame.
REQ-009 SHALL have port out_valid, output, 1: result valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-011 SHALL have port out_sum, output, ACC_W: frame sum.
REQ-012 SHALL have port out_ovf, output, 1: true frame sum exceeded 2^ACC_W-1.

Function
REQ-013 SHALL implement a state machine with states ACCUM, RESOLVE, OUTPUT.
REQ-014 In ACCUM, in_ready SHALL be 1; in RESOLVE and OUTPUT it SHALL be 0, and in_valid/in_data/in_last SHALL be ignored.
REQ-015 On an accepted beat (in_valid & in_ready), SHALL zero-extend in_data to ACC_W and compress it with the sum register S and carry register C in one 3:2 row: S <= S^C^d; C <= {maj[ACC_W-2:0],0}.
REQ-016 SHALL set sticky overflow flag when maj[ACC_W-1] of any compress is 1.
REQ-017 An accepted beat with in_last=1 SHALL be compressed and then move the state to RESOLVE.
REQ-018 RESOLVE SHALL add S and C bit-serially, LSB first, one bit per cycle for exactly ACC_W cycles, using a bit counter and a 1-bit carry register.
REQ-019 Carry out of the final resolve bit SHALL set the overflow flag.
REQ-020 If the last beat is accepted in cycle T, out_valid SHALL first be 1 in cycle T+ACC_W+1.
REQ-021 In OUTPUT, out_valid=1 and out_sum/out_ovf SHALL be held stable until out_valid & out_ready.
REQ-022 On the output handshake, S, C, overflow flag and counter SHALL clear and the state SHALL return to ACCUM, with in_ready=1 in the next cycle.
REQ-023 Without overflow, out_sum SHALL equal the sum of all frame operands; with overflow, it SHALL equal that sum mod 2^ACC_W unless REQ-027 applies.
REQ-024 A single-beat frame (in_last on first beat) SHALL be valid and produce that operand.

Reset
REQ-025 When rst_n=0, the block SHALL asynchronously enter ACCUM with S, C, counter, carry, overflow, out_sum, out_ovf and out_valid at 0; in_ready SHALL be 1 after release.
REQ-026 A reset in any state, including mid-RESOLVE or OUTPUT, SHALL discard the partial frame without producing a result.

Configuration
REQ-027 With macro CSA_ACC_SAT_EN defined, out_sum SHALL be all ones when out_ovf=1; without it, out_sum SHALL wrap; out_ovf SHALL behave the same in both builds.

Structure
REQ-028 The state enum and the default widths SHALL live in the shared package csa_pkg.
REQ-029 The 3:2 compress row SHALL be a sub-module csa_row(ACC_W), built from the existing full-adder cell; the resolve stage SHALL reuse one full-adder instance.

Verification (WIDTH=4, ACC_W=8)
REQ-030 Beats 15,15,15(last) -> out_sum=45, out_ovf=0, out_valid at T+9.
REQ-031 17 beats of 15 -> 255, ovf=0; 18 beats of 15 -> ovf=1, out_sum=14 (wrap) or 255 (CSA_ACC_SAT_EN).
REQ-032 out_ready held 0 for 5 cycles in OUTPUT -> out_sum/out_ovf stable, in_ready=0, in_valid pulses ignored.
REQ-033 rst_n pulsed low in 4th RESOLVE cycle -> out_valid=0, outputs 0, in_ready=1; next frame 3,4(last) -> 7.
REQ-034 Single beat 0 with last -> out_sum=0, ovf=0; then back-to-back frame 9(last) -> 9.
